// File: rtl/md_pkg.sv
// md_pkg: shared encodings, default latencies and FSM states for the multiply/divide sequencer
package md_pkg;
   localparam logic [2:0] MD_MULT  = 3'd0;
   localparam logic [2:0] MD_MULTU = 3'd1;
   localparam logic [2:0] MD_DIV   = 3'd2;
   localparam logic [2:0] MD_DIVU  = 3'd3;
   localparam logic [2:0] MD_MTHI  = 3'd4;
   localparam logic [2:0] MD_MTLO  = 3'd5;
   localparam int MULT_CYCLES_DEF = 5;
   localparam int DIV_CYCLES_DEF  = 10;
   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;
   function automatic logic is_div(input logic [2:0] op);
      return op == MD_DIV || op == MD_DIVU;
   endfunction
endpackage

// File: rtl/md_compute.sv
// md_compute: combinational {hi,lo} result for a latched multiply/divide op
module md_compute import md_pkg::*; (
   input  logic [2:0]  op_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic [63:0] res_o,
   output logic        div_by_zero_o
);
   logic [63:0] prod_s, prod_u;
   logic [31:0] mag_a, mag_b, div_s, div_u, quo_s, rem_s, quo_u, rem_u;
   // Signed product is the low 64 bits of the sign-extended operands' product
   assign prod_s = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};
   assign prod_u = {32'd0, a_i} * {32'd0, b_i};
   // Signed division on magnitudes avoids the 0x80000000 / -1 overflow corner
   assign mag_a  = a_i[31] ? -a_i : a_i;
   assign mag_b  = b_i[31] ? -b_i : b_i;
   // A zero divisor is replaced by 1 only to keep the divider defined; the result is discarded
   assign div_s  = (mag_b == 32'd0) ? 32'd1 : mag_b;
   assign div_u  = (b_i == 32'd0) ? 32'd1 : b_i;
   assign quo_s  = mag_a / div_s;
   assign rem_s  = mag_a % div_s;
   assign quo_u  = a_i / div_u;
   assign rem_u  = a_i % div_u;
   assign res_o  = (op_i == MD_MULT)  ? prod_s :
                   (op_i == MD_MULTU) ? prod_u :
                   (op_i == MD_DIV)   ? {a_i[31] ? -rem_s : rem_s, (a_i[31] ^ b_i[31]) ? -quo_s : quo_s} :
                                        {rem_u, quo_u};
   assign div_by_zero_o = is_div(op_i) && b_i == 32'd0;
endmodule

// File: rtl/md_seq_unit.sv
// md_seq_unit: E-stage multiply/divide sequencer owning HI/LO and the D-stage stall request
module md_seq_unit import md_pkg::*; #(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  md_op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        cancel,
   input  logic        md_in_d,
   output logic        busy,
   output logic        stall,
   output logic [31:0] hi,
   output logic [31:0] lo
);
   localparam logic [3:0] MULT_LAT = 4'(MULT_CYCLES - 1);
   localparam logic [3:0] DIV_LAT  = 4'(DIV_CYCLES - 1);
   state_e      state_q;
   logic [3:0]  cnt_q;
   logic [2:0]  op_q;
   logic [31:0] a_q, b_q, hi_q, lo_q;
   logic [63:0] res;
   logic        div_by_zero, accept;
   assign accept = start & ~cancel & (state_q == IDLE);
   md_compute u_compute (
      .op_i          (op_q),
      .a_i           (a_q),
      .b_i           (b_q),
      .res_o         (res),
      .div_by_zero_o (div_by_zero)
   );
   // Sequencer: latch operands on accept, count down the latency, commit HI/LO at zero
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         op_q    <= 3'd0;
         a_q     <= 32'd0;
         b_q     <= 32'd0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
      end else if (state_q == IDLE) begin
         if (accept && md_op <= MD_DIVU) begin
            op_q    <= md_op;
            a_q     <= A;
            b_q     <= B;
            cnt_q   <= is_div(md_op) ? DIV_LAT : MULT_LAT;
            state_q <= RUN;
         end else if (accept && md_op == MD_MTHI) begin
            hi_q <= A;
         end else if (accept && md_op == MD_MTLO) begin
            lo_q <= A;
         end
      end else if (cnt_q == 4'd0) begin
         if (!div_by_zero) {hi_q, lo_q} <= res;
         state_q <= IDLE;
      end else begin
         cnt_q <= cnt_q - 4'd1;
      end
   end
   assign busy  = state_q == RUN;
   assign stall = md_in_d & (busy | (start & ~cancel & (md_op <= MD_MTLO)));
   assign hi    = hi_q;
   assign lo    = lo_q;
endmodule

// File: tb/tb_md_seq_unit.sv
// tb_md_seq_unit: randomized and directed checks of md_seq_unit against an arithmetic reference model
module tb_md_seq_unit;
   localparam int ML = 5;
   localparam int DL = 10;
   logic        clk, reset, start, cancel, md_in_d;
   logic [2:0]  md_op;
   logic [31:0] A, B, hi, lo;
   logic        busy, stall;
   logic [31:0] m_hi, m_lo;
   int          errors = 0;
   int          checks = 0;

   md_seq_unit #(.MULT_CYCLES(ML), .DIV_CYCLES(DL)) dut (
      .clk(clk), .reset(reset), .start(start), .md_op(md_op), .A(A), .B(B),
      .cancel(cancel), .md_in_d(md_in_d), .busy(busy), .stall(stall), .hi(hi), .lo(lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] h, input logic [31:0] l);
      longint sa = longint'($signed(a));
      longint sb = longint'($signed(b));
      longint unsigned ua = 64'(a);
      longint unsigned ub = 64'(b);
      logic [63:0] r;
      case (op)
         3'd0: r = 64'(sa * sb);
         3'd1: r = ua * ub;
         3'd2: r = (b == 0) ? {h, l} : {32'(sa % sb), 32'(sa / sb)};
         3'd3: r = (b == 0) ? {h, l} : {32'(ua % ub), 32'(ua / ub)};
         3'd4: r = {a, l};
         3'd5: r = {h, a};
         default: r = {h, l};
      endcase
      return r;
   endfunction

   // Called at a negedge; returns at the first negedge with busy low after the op.
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic can, output int bc);
      start = 1'b1; md_op = op; A = a; B = b; cancel = can;
      if (!can && op <= 3'd5) {m_hi, m_lo} = ref_md(op, a, b, m_hi, m_lo);
      @(negedge clk);
      start = 1'b0; cancel = 1'b0; A = $urandom; B = $urandom;
      bc = 0;
      while (busy && bc < 40) begin
         bc++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      reset = 1'b0; start = 1'b0; cancel = 1'b0; md_in_d = 1'b0; md_op = 3'd0; A = 0; B = 0;
      m_hi = 0; m_lo = 0;
      #12;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall); end
      checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi got=%h exp=0", hi); end
      checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo got=%h exp=0", lo); end
      @(negedge clk); reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_mult;
      int bc;
      run_op(3'd0, 32'hFFFFFFFD, 32'd5, 1'b0, bc);
      checks++; if (bc != ML) begin errors++; $display("FAIL mult_busy got=%0d exp=%0d", bc, ML); end
      checks++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFF1) begin errors++; $display("FAIL mult_res got=%h_%h exp=ffffffff_fffffff1", hi, lo); end
   endtask

   task automatic test_multu_divu;
      int bc;
      run_op(3'd1, 32'hFFFFFFFF, 32'd2, 1'b0, bc);
      checks++; if (bc != ML) begin errors++; $display("FAIL multu_busy got=%0d exp=%0d", bc, ML); end
      checks++; if ({hi, lo} !== 64'h00000001_FFFFFFFE) begin errors++; $display("FAIL multu_res got=%h_%h exp=00000001_fffffffe", hi, lo); end
      run_op(3'd3, 32'd7, 32'd2, 1'b0, bc);
      checks++; if (bc != DL) begin errors++; $display("FAIL divu_busy got=%0d exp=%0d", bc, DL); end
      checks++; if ({hi, lo} !== {32'd1, 32'd3}) begin errors++; $display("FAIL divu_res got=%h_%h exp=00000001_00000003", hi, lo); end
   endtask

   task automatic test_div;
      int bc;
      run_op(3'd2, 32'hFFFFFFF9, 32'd2, 1'b0, bc);
      checks++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFD) begin errors++; $display("FAIL div_neg got=%h_%h exp=ffffffff_fffffffd", hi, lo); end
      run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, bc);
      checks++; if ({hi, lo} !== 64'h00000000_80000000) begin errors++; $display("FAIL div_ovf got=%h_%h exp=00000000_80000000", hi, lo); end
      run_op(3'd2, 32'd9, 32'hFFFFFFFC, 1'b0, bc);
      checks++; if ({hi, lo} !== 64'h00000001_FFFFFFFE) begin errors++; $display("FAIL div_negdivisor got=%h_%h exp=00000001_fffffffe", hi, lo); end
   endtask

   task automatic test_div_zero;
      int bc;
      run_op(3'd4, 32'h1234, 32'd0, 1'b0, bc);
      run_op(3'd5, 32'h5678, 32'd0, 1'b0, bc);
      checks++; if (bc != 0) begin errors++; $display("FAIL mt_busy got=%0d exp=0", bc); end
      run_op(3'd2, 32'd99, 32'd0, 1'b0, bc);
      checks++; if (bc != DL) begin errors++; $display("FAIL divz_busy got=%0d exp=%0d", bc, DL); end
      checks++; if ({hi, lo} !== {32'h1234, 32'h5678}) begin errors++; $display("FAIL divz_res got=%h_%h exp=00001234_00005678", hi, lo); end
      run_op(3'd3, 32'd99, 32'd0, 1'b0, bc);
      checks++; if ({hi, lo} !== {32'h1234, 32'h5678}) begin errors++; $display("FAIL divuz_res got=%h_%h exp=00001234_00005678", hi, lo); end
   endtask

   task automatic test_stall;
      int bc;
      start = 1'b1; md_op = 3'd2; A = 32'd100; B = 32'd7; md_in_d = 1'b0;
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL stall_no_d got=%b exp=0", stall); end
      md_in_d = 1'b1;
      #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL stall_start got=%b exp=1", stall); end
      {m_hi, m_lo} = ref_md(3'd2, 32'd100, 32'd7, m_hi, m_lo);
      @(negedge clk);
      start = 1'b0; A = 32'hFFFFFFFF; B = 32'd3;
      bc = 0;
      while (busy && bc < 40) begin
         checks++; if (stall !== 1'b1) begin errors++; $display("FAIL stall_busy cycle=%0d got=%b exp=1", bc, stall); end
         bc++;
         @(negedge clk);
      end
      checks++; if (bc != DL) begin errors++; $display("FAIL stall_busylen got=%0d exp=%0d", bc, DL); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL stall_release got=%b exp=0", stall); end
      checks++; if ({hi, lo} !== {32'd2, 32'd14}) begin errors++; $display("FAIL stall_res got=%h_%h exp=00000002_0000000e", hi, lo); end
      start = 1'b1; md_op = 3'd6;
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL stall_reserved got=%b exp=0", stall); end
      start = 1'b1; md_op = 3'd0; cancel = 1'b1;
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL stall_cancel got=%b exp=0", stall); end
      start = 1'b0; cancel = 1'b0; md_in_d = 1'b0;
   endtask

   task automatic test_cancel;
      int bc;
      logic [31:0] h0, l0;
      h0 = m_hi; l0 = m_lo;
      run_op(3'd0, 32'd6, 32'd7, 1'b1, bc);
      checks++; if (bc != 0) begin errors++; $display("FAIL cancel_mult_busy got=%0d exp=0", bc); end
      run_op(3'd4, 32'hDEAD, 32'd0, 1'b1, bc);
      checks++; if ({hi, lo} !== {h0, l0}) begin errors++; $display("FAIL cancel_res got=%h_%h exp=%h_%h", hi, lo, h0, l0); end
      run_op(3'd0, 32'd6, 32'd7, 1'b0, bc);
      checks++; if (bc != ML) begin errors++; $display("FAIL nocancel_busy got=%0d exp=%0d", bc, ML); end
      checks++; if ({hi, lo} !== {32'd0, 32'd42}) begin errors++; $display("FAIL nocancel_res got=%h_%h exp=00000000_0000002a", hi, lo); end
      run_op(3'd7, 32'h5555, 32'd1, 1'b0, bc);
      checks++; if (bc != 0 || {hi, lo} !== {32'd0, 32'd42}) begin errors++; $display("FAIL reserved_op busy=%0d got=%h_%h exp=0 00000000_0000002a", bc, hi, lo); end
   endtask

   task automatic test_back_to_back;
      int bc;
      run_op(3'd1, 32'h00012345, 32'h00010000, 1'b0, bc);
      run_op(3'd3, m_lo, m_hi | 32'd1, 1'b0, bc);
      checks++; if ({hi, lo} !== {m_hi, m_lo}) begin errors++; $display("FAIL b2b_res got=%h_%h exp=%h_%h", hi, lo, m_hi, m_lo); end
      checks++; if (bc != DL) begin errors++; $display("FAIL b2b_busy got=%0d exp=%0d", bc, DL); end
   endtask

   task automatic test_async_reset;
      int bc;
      run_op(3'd4, 32'hAAAA, 32'd0, 1'b0, bc);
      start = 1'b1; md_op = 3'd2; A = 32'd1000; B = 32'd3;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      checks++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL async_reset busy=%b hi=%h lo=%h exp=0 0 0", busy, hi, lo); end
      m_hi = 0; m_lo = 0;
      @(negedge clk); reset = 1'b1;
      run_op(3'd1, 32'd3, 32'd4, 1'b0, bc);
      checks++; if (bc != ML) begin errors++; $display("FAIL post_reset_busy got=%0d exp=%0d", bc, ML); end
      checks++; if ({hi, lo} !== {32'd0, 32'd12}) begin errors++; $display("FAIL post_reset_res got=%h_%h exp=00000000_0000000c", hi, lo); end
   endtask

   task automatic test_random;
      int bc, exp_bc;
      logic [2:0] op;
      logic [31:0] a, b;
      logic can;
      for (int i = 0; i < 60; i++) begin
         op = 3'($urandom_range(0, 7));
         a = ($urandom_range(0, 5) == 0) ? 32'h80000000 : $urandom;
         b = ($urandom_range(0, 5) == 0) ? 32'd0 : ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
         can = $urandom_range(0, 3) == 0;
         exp_bc = (!can && op <= 3'd3) ? ((op <= 3'd1) ? ML : DL) : 0;
         run_op(op, a, b, can, bc);
         checks++; if (bc != exp_bc) begin errors++; $display("FAIL rand_busy i=%0d op=%0d got=%0d exp=%0d", i, op, bc, exp_bc); end
         checks++; if ({hi, lo} !== {m_hi, m_lo}) begin errors++; $display("FAIL rand_res i=%0d op=%0d a=%h b=%h got=%h_%h exp=%h_%h", i, op, a, b, hi, lo, m_hi, m_lo); end
      end
   endtask

   initial begin
      test_reset;
      test_mult;
      test_multu_divu;
      test_div;
      test_div_zero;
      test_stall;
      test_cancel;
      test_back_to_back;
      test_async_reset;
      test_random;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
